pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the en/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable/select. It resolves four hazard sources: D-cache miss, I-cache miss, load-use dependency and EX-stage branch/jump redirect. A small FSM handles redirects that occur while an I-fetch is still outstanding, by latching the target and discarding the wrong-path fetch.

Parameters:
XLEN, 32, PC/target width
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_read  in  1  fetch request active
imem_resp  in  1  fetch data valid this cycle
dmem_read  in  1  MEM-stage load request
dmem_write  in  1  MEM-stage store request
dmem_resp  in  1  D-cache access complete
idex_mem_read  in  1  instruction in EX is a load
idex_rd  in  5  EX destination register
ifid_rs1  in  5  ID source 1
ifid_rs2  in  5  ID source 2
ifid_uses_rs1  in  1  ID instruction reads rs1
ifid_uses_rs2  in  1  ID instruction reads rs2
br_taken  in  1  EX resolved taken branch/jal/jalr
br_target  in  XLEN  redirect target from EX
pc_en  out  1  PC register load enable
pc_sel_target  out  1  1: PC loads redirect_pc; 0: PC loads pc+4
redirect_pc  out  XLEN  redirect address
ifid_en, ifid_flush  out  1 each  IF/ID control
idex_en, idex_flush  out  1 each  ID/EX control
exmem_en, exmem_flush  out  1 each  EX/MEM control
memwb_en, memwb_flush  out  1 each  MEM/WB control
fetch_discard  out  1  current imem response is wrong-path
stall_cnt  out  CNT_W  cycles with any stage held
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Reset is synchronous on the clk edge with rst=1.
  - Reset state: state=RUN, pend_target=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, all en/flush outputs, pc_en, pc_sel_target and fetch_discard are 0; redirect_pc=0.
  - rst asserted in any state returns to RUN next cycle. A pending redirect is dropped.
- Derived terms (all outputs are combinational from state plus inputs):
  - dstall = (dmem_read|dmem_write) & ~dmem_resp
  - istall = imem_read & ~imem_resp
  - lu = idex_mem_read & idex_rd!=0 & ((ifid_uses_rs1 & ifid_rs1==idex_rd) | (ifid_uses_rs2 & ifid_rs2==idex_rd))
- A flush is only meaningful with en=1. The controller never asserts flush without en.
- The I-cache re-presents imem_resp/rdata every cycle imem_read is held at the same address.
- FSM states: RUN, SQUASH, REDIRECT_READY. Priority within a state, highest first:
  1. dstall: all four en=0, pc_en=0. The state holds, except that in SQUASH an imem_resp moves the state to REDIRECT_READY.
  2. RUN & br_taken & ~istall: pc_en=1, pc_sel_target=1, redirect_pc=br_target. ifid and idex get en=1/flush=1. exmem and memwb get en=1. flush_cnt+1.
  3. RUN & br_taken & istall: latch pend_target<=br_target and go to SQUASH. ifid and idex get en=1/flush=1. exmem and memwb get en=1. pc_en=0. flush_cnt+1.
  4. RUN & lu: pc_en=0, ifid_en=0, idex en=1/flush=1 (bubble). exmem and memwb get en=1.
  5. RUN & istall: pc_en=0, ifid en=1/flush=1. All other stages get en=1.
  6. RUN otherwise: all en=1, pc_en=1, pc_sel_target=0.
- SQUASH (no dstall):
  - Downstream stages advance: exmem and memwb get en=1; idex gets en=1/flush=1.
  - ifid gets en=1/flush=1. pc_en=0.
  - br_taken is ignored, since EX holds a bubble.
  - On imem_resp: fetch_discard=1, pc_en=1, pc_sel_target=1, redirect_pc=pend_target, then go to RUN.
- REDIRECT_READY (entered only under dstall): once dstall clears, behaves as SQUASH with imem_resp=1 and returns to RUN.
- stall_cnt increments each non-reset cycle in which any of ifid_en, idex_en, exmem_en, memwb_en is 0, or in which pc_en=0 without a flush. Both counters wrap modulo 2^CNT_W.
- Latency: a redirect reaches the PC in 0 cycles when the fetch is idle or complete, otherwise on the cycle of the I-cache response.

Test Plan:
- Load-use: EX holds lw x5 (idex_mem_read=1, idex_rd=5); ID holds add using rs2=5 -> exactly one cycle of pc_en=0, ifid_en=0, idex_en=1/idex_flush=1. Same case with idex_rd=0 -> no stall.
- Taken branch, fetch idle: br_taken=1, br_target=0x80, imem_resp=1 -> same cycle pc_en=1, pc_sel_target=1, redirect_pc=0x80, ifid_flush=idex_flush=1; flush_cnt=1.
- Redirect during I-miss: br_taken=1, br_target=0x1A4, imem_read=1, imem_resp=0 for 3 more cycles -> state SQUASH, pc_en=0. On resp: fetch_discard=1, redirect_pc=0x1A4, pc_en=1; back to RUN.
- D-miss over SQUASH: enter SQUASH, then dmem_read=1 without dmem_resp while imem_resp arrives -> all en=0, state REDIRECT_READY. After dmem_resp: fetch_discard=1, redirect_pc=pend_target.
- D-miss freeze: dmem_write=1, dmem_resp=0 for 4 cycles -> all en=0, pc_en=0 for 4 cycles; stall_cnt +4.
- Reset mid-SQUASH: assert rst -> next cycle state RUN, counters 0, all outputs 0 while rst=1; the pending target is never emitted.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard sequencer and the pipeline datapath.
// The datapath side (master) reports hazard sources; the sequencer (slave) returns stage controls.
interface pipeline_hazard_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             imem_read;
    logic             imem_resp;
    logic             dmem_read;
    logic             dmem_write;
    logic             dmem_resp;
    logic             idex_mem_read;
    logic [4:0]       idex_rd;
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             ifid_uses_rs1;
    logic             ifid_uses_rs2;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;

    logic             pc_en;
    logic             pc_sel_target;
    logic [XLEN-1:0]  redirect_pc;
    logic             ifid_en, ifid_flush;
    logic             idex_en, idex_flush;
    logic             exmem_en, exmem_flush;
    logic             memwb_en, memwb_flush;
    logic             fetch_discard;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
               idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
               br_taken, br_target,
        input  pc_en, pc_sel_target, redirect_pc, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, fetch_discard, stall_cnt, flush_cnt
    );

    modport slave (
        input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
               idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
               br_taken, br_target,
        output pc_en, pc_sel_target, redirect_pc, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, fetch_discard, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: D-miss freeze, load-use bubble,
// I-miss hold, and EX redirects (deferred past an outstanding fetch via SQUASH).
module pipeline_hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, SQUASH, REDIRECT_READY} state_t;

    state_t           state, state_nx;
    logic [XLEN-1:0]  pend_target, pend_nx;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             dstall, istall, lu;
    logic             pc_en, pc_sel, discard;
    logic [XLEN-1:0]  rpc;
    logic             ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en;
    logic             inc_flush, inc_stall;

    assign dstall = (bus.dmem_read | bus.dmem_write) & ~bus.dmem_resp;
    assign istall = bus.imem_read & ~bus.imem_resp;
    assign lu     = bus.idex_mem_read & (bus.idex_rd != 5'd0) &
                    ((bus.ifid_uses_rs1 & (bus.ifid_rs1 == bus.idex_rd)) |
                     (bus.ifid_uses_rs2 & (bus.ifid_rs2 == bus.idex_rd)));

    always_comb begin
        state_nx  = state;
        pend_nx   = pend_target;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        discard   = 1'b0;
        rpc       = '0;
        ifid_en   = 1'b0;
        ifid_fl   = 1'b0;
        idex_en   = 1'b0;
        idex_fl   = 1'b0;
        exmem_en  = 1'b0;
        memwb_en  = 1'b0;
        inc_flush = 1'b0;
        if (!rst) begin
            if (dstall) begin
                // Whole pipe frozen; an I-response arriving now must not be lost.
                if (state == SQUASH && bus.imem_resp)
                    state_nx = REDIRECT_READY;
            end else begin
                case (state)
                    RUN: begin
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        idex_en  = 1'b1;
                        if (bus.br_taken) begin
                            ifid_en   = 1'b1;
                            ifid_fl   = 1'b1;
                            idex_fl   = 1'b1;
                            inc_flush = 1'b1;
                            if (istall) begin
                                pend_nx  = bus.br_target;
                                state_nx = SQUASH;
                            end else begin
                                pc_en  = 1'b1;
                                pc_sel = 1'b1;
                                rpc    = bus.br_target;
                            end
                        end else if (lu) begin
                            idex_fl = 1'b1;
                        end else if (istall) begin
                            ifid_en = 1'b1;
                            ifid_fl = 1'b1;
                        end else begin
                            ifid_en = 1'b1;
                            pc_en   = 1'b1;
                        end
                    end
                    SQUASH, REDIRECT_READY: begin
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        idex_en  = 1'b1;
                        idex_fl  = 1'b1;
                        ifid_en  = 1'b1;
                        ifid_fl  = 1'b1;
                        if (state == REDIRECT_READY || bus.imem_resp) begin
                            discard  = 1'b1;
                            pc_en    = 1'b1;
                            pc_sel   = 1'b1;
                            rpc      = pend_target;
                            state_nx = RUN;
                        end
                    end
                    default: state_nx = RUN;
                endcase
            end
        end
    end

    // A held PC alongside a flush is a redirect in progress, not a stall.
    assign inc_stall = ~(ifid_en & idex_en & exmem_en & memwb_en) |
                       (~pc_en & ~(ifid_fl | idex_fl));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pend_target <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state       <= state_nx;
            pend_target <= pend_nx;
            stall_cnt   <= stall_cnt + CNT_W'(inc_stall);
            flush_cnt   <= flush_cnt + CNT_W'(inc_flush);
        end
    end

    assign bus.pc_en         = pc_en;
    assign bus.pc_sel_target = pc_sel;
    assign bus.redirect_pc   = rpc;
    assign bus.fetch_discard = discard;
    assign bus.ifid_en       = ifid_en;
    assign bus.ifid_flush    = ifid_fl;
    assign bus.idex_en       = idex_en;
    assign bus.idex_flush    = idex_fl;
    assign bus.exmem_en      = exmem_en;
    assign bus.exmem_flush   = 1'b0;
    assign bus.memwb_en      = memwb_en;
    assign bus.memwb_flush   = 1'b0;
    assign bus.stall_cnt     = stall_cnt;
    assign bus.flush_cnt     = flush_cnt;
endmodule
